// File: rtl/clock_gen.sv
// CPU clock generator: divides clk_i into a 50%-duty CPU clock with run/stop, single-step,
// halt and selectable speed. Optional button debounce is enabled by defining CLK_GEN_DEBOUNCE_EN.
module clock_gen #(
  parameter int CNT_W         = 32,
  parameter int NUM_SPEEDS    = 4,
  parameter int BASE_HALF     = 12500000,
  parameter int SPEED_DIV     = 10,
  parameter int START_RUNNING = 1,
  parameter int DEB_CYCLES    = 250000
) (
  input  logic                          clk_i,
  input  logic                          rst,
  input  logic                          start_stop_i,
  input  logic                          step_i,
  input  logic                          speed_i,
  input  logic                          halt_i,
  output logic                          clk,
  output logic                          clk_rise_o,
  output logic                          running_o,
  output logic                          halted_o,
  output logic [$clog2(NUM_SPEEDS)-1:0] speed_idx_o
);

  localparam int SPD_W = $clog2(NUM_SPEEDS);
  localparam int TAB_N = 1 << SPD_W;

  typedef logic [TAB_N-1:0][CNT_W-1:0] half_tab_t;

  // Unused table slots repeat the fastest half-period; they are unreachable because the index wraps.
  function automatic half_tab_t build_half_tab();
    half_tab_t tab;
    longint    h;
    h = longint'(BASE_HALF);
    for (int k = 0; k < TAB_N; k++) begin
      tab[k] = CNT_W'(h);
      if (k < NUM_SPEEDS - 1) h = h / longint'(SPEED_DIV);
    end
    return tab;
  endfunction

  localparam half_tab_t HALF_TAB = build_half_tab();

  if (NUM_SPEEDS < 2 || HALF_TAB[NUM_SPEEDS-1] == '0 || DEB_CYCLES < 1) begin : g_bad_cfg
    $error("clock_gen: invalid parameter set");
  end

  typedef enum logic [1:0] {ST_RUN, ST_STOP, ST_STEP, ST_HALT} state_t;

  logic [2:0] btn_raw;
  logic [2:0] sync_p0, sync_p1;
  logic [2:0] btn_lvl, lvl_prev;
  logic [2:0] evt;
  logic       evt_ss, evt_step, evt_spd;

  assign btn_raw = {speed_i, step_i, start_stop_i};

  // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk_i) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef CLK_GEN_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [2:0]            flt;
  logic [2:0][DEB_W-1:0] deb_cnt;

  // A level change is accepted only after it has persisted for DEB_CYCLES cycles
  always_ff @(posedge clk_i) begin
    if (rst) begin
      flt     <= '0;
      deb_cnt <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (sync_p1[b] == flt[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_W'(DEB_CYCLES - 1)) begin
          flt[b]     <= sync_p1[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
        end
      end
    end
  end

  assign btn_lvl = flt;
`else
  assign btn_lvl = sync_p1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst) lvl_prev <= '0;
    else     lvl_prev <= btn_lvl;
  end

  assign evt      = btn_lvl & ~lvl_prev;
  assign evt_ss   = evt[0];
  assign evt_step = evt[1];
  assign evt_spd  = evt[2];

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   half_cur;
  logic               tc;
  logic               clk_nxt, rise_nxt;
  logic               stop_pend, pend_nxt;
  logic               halt_pend, hpend_nxt;

  assign half_cur = HALF_TAB[speed_idx_o];
  // >= rather than == so a switch to a shorter period toggles at once instead of wrapping
  assign tc       = (cnt >= half_cur - CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state      <= (START_RUNNING != 0) ? ST_RUN : ST_STOP;
      cnt        <= '0;
      clk        <= 1'b0;
      clk_rise_o <= 1'b0;
      stop_pend  <= 1'b0;
      halt_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clk        <= clk_nxt;
      clk_rise_o <= rise_nxt;
      stop_pend  <= pend_nxt;
      halt_pend  <= hpend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clk_nxt   = clk;
    rise_nxt  = 1'b0;
    pend_nxt  = stop_pend;
    hpend_nxt = halt_pend;
    case (state)
      ST_RUN: begin
        if (!clk && (halt_i || evt_ss)) begin
          state_nxt = halt_i ? ST_HALT : ST_STOP;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
          hpend_nxt = 1'b0;
        end else if (tc) begin
          cnt_nxt  = '0;
          clk_nxt  = ~clk;
          rise_nxt = ~clk;
          // A stop requested during the high phase takes effect on its natural falling edge
          if (clk && (stop_pend || halt_i || evt_ss)) begin
            state_nxt = (halt_pend || halt_i) ? ST_HALT : ST_STOP;
            pend_nxt  = 1'b0;
            hpend_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (clk && (halt_i || evt_ss)) begin
            pend_nxt  = 1'b1;
            hpend_nxt = halt_pend || halt_i;
          end
        end
      end
      ST_STOP: begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
        if (evt_ss) begin
          state_nxt = ST_RUN;
        end else if (evt_step) begin
          state_nxt = ST_STEP;
          clk_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end
      end
      ST_STEP: begin
        hpend_nxt = halt_pend || halt_i;
        if (tc) begin
          state_nxt = (halt_pend || halt_i) ? ST_HALT : ST_STOP;
          cnt_nxt   = '0;
          clk_nxt   = 1'b0;
          hpend_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    running_o = (state == ST_RUN);
    halted_o  = (state == ST_HALT);
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      speed_idx_o <= '0;
    end else if (evt_spd) begin
      if (speed_idx_o == SPD_W'(NUM_SPEEDS - 1)) speed_idx_o <= '0;
      else                                       speed_idx_o <= speed_idx_o + SPD_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen with half-periods 8,4,2,1 and START_RUNNING=1.
module tb_clock_gen;

  logic       clk_i = 1'b0;
  logic       rst;
  logic       start_stop_i, step_i, speed_i, halt_i;
  logic       clk, clk_rise_o, running_o, halted_o;
  logic [1:0] speed_idx_o;

  int checks   = 0;
  int failures = 0;
  int rise_cnt = 0;

  clock_gen #(
    .CNT_W(8), .NUM_SPEEDS(4), .BASE_HALF(8), .SPEED_DIV(2),
    .START_RUNNING(1), .DEB_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .rst(rst), .start_stop_i(start_stop_i), .step_i(step_i),
    .speed_i(speed_i), .halt_i(halt_i), .clk(clk), .clk_rise_o(clk_rise_o),
    .running_o(running_o), .halted_o(halted_o), .speed_idx_o(speed_idx_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (clk_rise_o === 1'b1) rise_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(output bit ok);
    int n;
    n = 0;
    while (clk_rise_o !== 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    ok = (clk_rise_o === 1'b1);
  endtask

  task automatic measure_period(output int p);
    bit ok;
    wait_rise(ok);
    p = 0;
    do begin
      tick(1);
      p++;
    end while (clk_rise_o !== 1'b1 && p < 64);
  endtask

  initial begin
    int r0, p;
    bit ok;
    int exp_idx[4]  = '{1, 2, 3, 0};
    int exp_half[4] = '{4, 2, 1, 8};

    rst = 1'b1; start_stop_i = 1'b0; step_i = 1'b0; speed_i = 1'b0; halt_i = 1'b0;
    tick(3);
    check("rst_clk", clk, 0);
    check("rst_rise", clk_rise_o, 0);
    check("rst_running", running_o, 1);
    check("rst_halted", halted_o, 0);
    check("rst_speed", speed_idx_o, 0);

    // 1: free run at half=8
    rst = 1'b0;
    r0 = rise_cnt;
    tick(7);
    check("t1_low_before_rise", clk, 0);
    tick(1);
    check("t1_first_rise_clk", clk, 1);
    check("t1_first_rise_pulse", clk_rise_o, 1);
    tick(1);
    check("t1_pulse_one_cycle", clk_rise_o, 0);
    tick(7);
    check("t1_fall_at_16", clk, 0);
    tick(48);
    check("t1_rise_count", rise_cnt - r0, 4);
    check("t1_running", running_o, 1);

    // 2: speed cycling with wrap
    for (int i = 0; i < 4; i++) begin
      speed_i = 1'b1;
      tick(2);
      check("t2_speed_latency", speed_idx_o, (i == 0) ? 0 : exp_idx[i-1]);
      tick(1);
      check("t2_speed_idx", speed_idx_o, exp_idx[i]);
      speed_i = 1'b0;
      measure_period(p);
      check("t2_period", p, 2 * exp_half[i]);
      tick(10);
    end

    // 3: stop requested during high phase at counter=2
    wait_rise(ok);
    check("t3_found_rise", ok, 1);
    start_stop_i = 1'b1;
    tick(3);
    check("t3_still_high", clk, 1);
    check("t3_still_running", running_o, 1);
    start_stop_i = 1'b0;
    tick(4);
    check("t3_high_last", clk, 1);
    tick(1);
    check("t3_fell", clk, 0);
    check("t3_stopped", running_o, 0);
    r0 = rise_cnt;
    tick(40);
    check("t3_stays_low", clk, 0);
    check("t3_no_edges", rise_cnt - r0, 0);

    // 4: two single steps
    for (int s = 0; s < 2; s++) begin
      step_i = 1'b1;
      tick(2);
      check("t4_pre_step", clk, 0);
      tick(1);
      check("t4_step_clk", clk, 1);
      check("t4_step_pulse", clk_rise_o, 1);
      check("t4_step_not_running", running_o, 0);
      step_i = 1'b0;
      tick(7);
      check("t4_step_high_end", clk, 1);
      tick(1);
      check("t4_step_low", clk, 0);
      tick(19);
    end
    check("t4_rise_count", rise_cnt - r0, 2);

    // 5: start_stop and step together
    start_stop_i = 1'b1;
    step_i = 1'b1;
    tick(3);
    check("t5_running", running_o, 1);
    check("t5_no_step_clk", clk, 0);
    check("t5_no_step_pulse", clk_rise_o, 0);
    start_stop_i = 1'b0;
    step_i = 1'b0;
    tick(7);
    check("t5_low_before", clk, 0);
    tick(1);
    check("t5_first_rise", clk, 1);

    // 6: halt during high phase, buttons ignored, speed still steps, reset recovers
    wait_rise(ok);
    check("t6_found_rise", ok, 1);
    halt_i = 1'b1;
    tick(7);
    check("t6_high_kept", clk, 1);
    check("t6_not_halted_yet", halted_o, 0);
    tick(1);
    check("t6_clk_low", clk, 0);
    check("t6_halted", halted_o, 1);
    check("t6_not_running", running_o, 0);
    halt_i = 1'b0;
    r0 = rise_cnt;
    start_stop_i = 1'b1; step_i = 1'b1; speed_i = 1'b1;
    tick(6);
    check("t6_still_halted", halted_o, 1);
    check("t6_ignored_clk", clk, 0);
    check("t6_ignored_edges", rise_cnt - r0, 0);
    check("t6_speed_in_halt", speed_idx_o, 1);
    start_stop_i = 1'b0; step_i = 1'b0; speed_i = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("t6_rst_running", running_o, 1);
    check("t6_rst_halted", halted_o, 0);
    check("t6_rst_speed", speed_idx_o, 0);
    rst = 1'b0;

    // reset mid high phase
    wait_rise(ok);
    check("t7_found_rise", ok, 1);
    tick(2);
    check("t7_high", clk, 1);
    rst = 1'b1;
    tick(1);
    check("t7_rst_drops_clk", clk, 0);
    rst = 1'b0;
    tick(7);
    check("t7_low_before", clk, 0);
    tick(1);
    check("t7_rise_after_rst", clk, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
